// File: rtl/display_pkg.sv
// Shared constants for the multiplexed display: segment bit positions and
// the active-high hex-to-7-segment table (bit 6 = a ... bit 0 = g).
package display_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed hex display driver: shadow registers, slot prescaler,
// digit scan index and registered, polarity-adjusted segment/anode outputs.
module display_mux
  import display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  slot_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_V    = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    sh_val;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_blank;

  logic [3:0]             cur_nib;
  logic [6:0]             dec_seg;
  logic [DIGITS-1:0]      lz_dark;
  logic                   higher_zero;
  logic                   lit;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;
  logic [DIGITS-1:0]      an_nxt;

  // load is a single-cycle strobe sampled on every rising edge; no ready,
  // the shadows accept it unconditionally, even on a slot boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      slot_start <= 1'b0;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
      slot_start <= (presc == PRESC_LAST);
      if (load) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end
    end
  end

  // A digit is a leading zero when it and every digit to its left are 0.
  always_comb begin
    lz_dark     = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (sh_val[4*i +: 4] == 4'h0);
      lz_dark[i]  = LZ_SUPPRESS & (i != 0) & higher_zero;
    end
  end

  assign cur_nib = sh_val[4*int'(idx) +: 4];

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    lit     = (presc >= BLANK_V) & ~sh_blank[idx] & ~lz_dark[idx];
    seg_nxt = lit ? dec_seg : 7'b0;
    dp_nxt  = lit & sh_dp[idx];
    an_nxt  = '0;
    if (lit) an_nxt[idx] = 1'b1;
  end

  // Polarity is applied only here so all internal logic stays active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{SEG_ACT_LOW}};
      dp  <= SEG_ACT_LOW;
      an  <= {DIGITS{AN_ACT_LOW}};
    end else begin
      seg <= seg_nxt ^ {7{SEG_ACT_LOW}};
      dp  <= dp_nxt ^ SEG_ACT_LOW;
      an  <= an_nxt ^ {DIGITS{AN_ACT_LOW}};
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Randomized bench for display_mux: two instances (leading-zero suppression
// off/on) compared every cycle against a cycle-count based reference model.
module tb_display_mux;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int W  = 13;  // {slot_start, dp, an[3:0], seg[6:0]}

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        load  = 1'b0;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;
  logic        ss0, ss1;

  always #5 clk = ~clk;

  display_mux #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC),
                .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1), .LZ_SUPPRESS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank(blank),
    .load(load), .seg(seg0), .dp(dp0), .an(an0), .slot_start(ss0));

  display_mux #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC),
                .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1), .LZ_SUPPRESS(1'b1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank(blank),
    .load(load), .seg(seg1), .dp(dp1), .an(an1), .slot_start(ss1));

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference state: edges seen since reset release plus the loaded shadows.
  int          cnt = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;

  string seg_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    string s;
    logic [6:0] r;
    s = seg_str[n];
    r = '0;
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] off_vec();
    return {1'b0, 1'b1, 4'hf, 7'h7f};
  endfunction

  function automatic logic [W-1:0] model_out(input bit lz);
    int   phase, slot;
    bit   lit, ss;
    logic [3:0] nib, an_e;
    logic [6:0] seg_e;
    phase = cnt % SD;
    slot  = (cnt / SD) % D;
    nib   = m_val[4*slot +: 4];
    lit   = (phase >= BC) && !m_blank[slot] &&
            !(lz && slot != 0 && (m_val >> (4*slot)) == 16'h0);
    ss    = ((cnt + 1) % SD) == 0;
    an_e  = lit ? ~(4'b0001 << slot) : 4'hf;
    seg_e = lit ? ~seg_of(nib) : 7'h7f;
    return {ss, ~(lit & m_dp[slot]), an_e, seg_e};
  endfunction

  task automatic model_step();
    exp_q.push_back(model_out(1'b0));
    exp_q.push_back(model_out(1'b1));
    if (load) begin
      m_val   = value;
      m_dp    = dp_in;
      m_blank = blank;
    end
    cnt++;
  endtask

  task automatic model_reset();
    cnt     = 0;
    m_val   = '0;
    m_dp    = '0;
    m_blank = '0;
    exp_q.delete();
  endtask

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", tag, got, exp, cnt, $time);
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] e0, e1;
    if (exp_q.size() < 2) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_underflow: got %0d entries expected 2", exp_q.size());
    end else begin
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      check_val("seg",        seg0, e0[6:0]);
      check_val("an",         an0,  e0[10:7]);
      check_val("dp",         dp0,  e0[11]);
      check_val("slot_start", ss0,  e0[12]);
      check_val("lz_seg",     seg1, e1[6:0]);
      check_val("lz_an",      an1,  e1[10:7]);
      check_val("lz_dp",      dp1,  e1[11]);
      check_val("lz_slot",    ss1,  e1[12]);
    end
  endtask

  task automatic tick(input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    load  = ld;
    value = v;
    dp_in = d;
    blank = b;
    @(posedge clk);
    if (rst_n) model_step();
    else begin
      exp_q.push_back(off_vec());
      exp_q.push_back(off_vec());
    end
    #1 compare_all();
    #1;
  endtask

  task automatic run_until_slot(input int slot, input int phase);
    for (int g = 0; g < 64; g++) begin
      if (((cnt / SD) % D) == slot && (cnt % SD) == phase) break;
      tick(1'b0, value, dp_in, blank);
    end
  endtask

  initial begin
    logic [15:0] rv;
    repeat (3) tick(1'b0, 16'h0, 4'h0, 4'h0);
    #1 rst_n = 1'b1;

    repeat (20) tick(1'b0, 16'h0, 4'h0, 4'h0);
    tick(1'b1, 16'h12AF, 4'h0, 4'h0);
    repeat (20) tick(1'b0, 16'h12AF, 4'h0, 4'h0);
    tick(1'b1, 16'h12AF, 4'b0001, 4'b0100);
    repeat (20) tick(1'b0, 16'h12AF, 4'b0001, 4'b0100);
    tick(1'b1, 16'h0070, 4'h0, 4'h0);
    repeat (20) tick(1'b0, 16'h0070, 4'h0, 4'h0);
    tick(1'b1, 16'h0000, 4'h0, 4'h0);
    repeat (20) tick(1'b0, 16'h0000, 4'h0, 4'h0);

    // Asynchronous reset in the middle of digit 2's lit time.
    tick(1'b1, 16'h3456, 4'hf, 4'h0);
    run_until_slot(2, 2);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(off_vec());
    exp_q.push_back(off_vec());
    compare_all();
    repeat (2) tick(1'b0, 16'h3456, 4'hf, 4'h0);
    #1 rst_n = 1'b1;
    repeat (20) tick(1'b0, 16'h3456, 4'hf, 4'h0);

    // Load landing exactly on the 3 -> 0 index wrap.
    tick(1'b1, 16'h4321, 4'h0, 4'h0);
    run_until_slot(3, 3);
    tick(1'b1, 16'hABC9, 4'h2, 4'h0);
    repeat (20) tick(1'b0, 16'h0, 4'h0, 4'h0);

    repeat (400) begin
      rv = '0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 1) rv[4*k +: 4] = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 7) == 0, rv, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
